timer_datapath: RTL and testbench

TIMER_DATAPATH -- requirements
Module: timer_datapath

---
 rtl/timer_datapath.sv | 130 +++++++++++++
 tb/tb_timer_datapath.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/timer_datapath.sv
`default_nettype none
//==============================================================================
// Module      : timer_datapath
// Description : BCD mm:ss countdown datapath with one-second prescaler,
//               preset clamping, completion flag and finish flasher.
// Revision    : 1.0 - initial release
//==============================================================================
module timer_datapath #(
   parameter int TICKS_PER_SEC = 50000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] state,
   input  logic [7:0] sw,
   output logic [7:0] sec,
   output logic [7:0] min,
   output logic       cntfin,
   output logic [9:0] ledr
);

   localparam int unsigned      c_PW        = $clog2(TICKS_PER_SEC);
   localparam logic [c_PW-1:0]  c_TERM      = c_PW'(TICKS_PER_SEC - 1);

   localparam logic [2:0]       c_ST_SETSEC = 3'd0;
   localparam logic [2:0]       c_ST_SETMIN = 3'd1;
   localparam logic [2:0]       c_ST_STOP   = 3'd2;
   localparam logic [2:0]       c_ST_START  = 3'd3;
   localparam logic [2:0]       c_ST_FINISH = 3'd4;
   localparam logic [2:0]       c_ST_RESET  = 3'd5;

   logic [c_PW-1:0] r_presc;
   logic            r_flash;

   logic            w_run;
   logic            w_tick;
   logic            w_zero;
   logic [c_PW-1:0] w_presc_nxt;
   logic [7:0]      w_sec_dec;
   logic [7:0]      w_min_dec;
   logic [7:0]      w_sec_clamp;
   logic [7:0]      w_min_clamp;

   assign w_run       = (state == c_ST_START) || (state == c_ST_FINISH);
   assign w_tick      = w_run && (r_presc == c_TERM);
   assign w_presc_nxt = (r_presc == c_TERM) ? '0 : r_presc + 1'b1;
   assign w_zero      = (sec == 8'h00) && (min == 8'h00);

   // Seconds tens never exceed 5; every other digit never exceeds 9.
   assign w_sec_clamp[7:4] = (sw[7:4] > 4'd5) ? 4'd5 : sw[7:4];
   assign w_sec_clamp[3:0] = (sw[3:0] > 4'd9) ? 4'd9 : sw[3:0];
   assign w_min_clamp[7:4] = (sw[7:4] > 4'd9) ? 4'd9 : sw[7:4];
   assign w_min_clamp[3:0] = (sw[3:0] > 4'd9) ? 4'd9 : sw[3:0];

   assign ledr = {10{r_flash}};

   // One-second BCD decrement with borrow chain; only used when time is nonzero.
   always_comb begin
      w_sec_dec = sec;
      w_min_dec = min;
      if (sec[3:0] != 4'd0) begin
         w_sec_dec[3:0] = sec[3:0] - 4'd1;
      end else begin
         w_sec_dec[3:0] = 4'd9;
         if (sec[7:4] != 4'd0) begin
            w_sec_dec[7:4] = sec[7:4] - 4'd1;
         end else begin
            w_sec_dec[7:4] = 4'd5;
            if (min[3:0] != 4'd0) begin
               w_min_dec[3:0] = min[3:0] - 4'd1;
            end else begin
               w_min_dec[3:0] = 4'd9;
               w_min_dec[7:4] = min[7:4] - 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sec     <= 8'h00;
         min     <= 8'h00;
         cntfin  <= 1'b0;
         r_flash <= 1'b0;
         r_presc <= '0;
      end else begin
         // Completion flag looks at the time as it stood before this edge.
         cntfin <= w_run && w_zero;
         case (state)
            c_ST_RESET: begin
               sec     <= 8'h00;
               min     <= 8'h00;
               r_flash <= 1'b0;
               r_presc <= '0;
            end
            c_ST_SETSEC: begin
               sec     <= w_sec_clamp;
               r_flash <= 1'b0;
               r_presc <= '0;
            end
            c_ST_SETMIN: begin
               min     <= w_min_clamp;
               r_flash <= 1'b0;
               r_presc <= '0;
            end
            c_ST_STOP: begin
               r_flash <= 1'b0;
            end
            c_ST_START: begin
               r_flash <= 1'b0;
               r_presc <= w_presc_nxt;
               if (w_tick && !w_zero) begin
                  sec <= w_sec_dec;
                  min <= w_min_dec;
               end
            end
            c_ST_FINISH: begin
               r_presc <= w_presc_nxt;
               if (w_tick) begin
                  r_flash <= ~r_flash;
               end
            end
            default: begin
               // Undefined codes freeze the datapath.
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_timer_datapath.sv
`default_nettype none
//==============================================================================
// Module      : tb_timer_datapath
// Description : Directed and randomized checks of timer_datapath against a
//               seconds-count reference model.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_timer_datapath;

   localparam int c_TPS = 4;

   logic       clk;
   logic       rst;
   logic [2:0] state;
   logic [7:0] sw;
   logic [7:0] sec;
   logic [7:0] min;
   logic       cntfin;
   logic [9:0] ledr;

   int n_vec;
   int n_err;

   // Reference model: time held as total seconds.
   int m_t;
   int m_p;
   bit m_fl;
   bit m_cf;

   timer_datapath #(.TICKS_PER_SEC(c_TPS)) dut (
      .clk    (clk),
      .rst    (rst),
      .state  (state),
      .sw     (sw),
      .sec    (sec),
      .min    (min),
      .cntfin (cntfin),
      .ledr   (ledr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] to_bcd(input int v);
      return 8'(((v / 10) << 4) + (v % 10));
   endfunction

   function automatic int lim(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input logic r, input logic [2:0] st, input logic [7:0] s);
      int  mm;
      int  ss;
      bit  tick;
      mm = m_t / 60;
      ss = m_t % 60;
      if (r) begin
         m_t = 0; m_p = 0; m_fl = 0; m_cf = 0;
      end else begin
         tick = (st == 3 || st == 4) && (m_p == c_TPS - 1);
         m_cf = (st == 3 || st == 4) && (m_t == 0);
         case (st)
            3'd0: begin
               ss   = lim(int'(s[7:4]), 5) * 10 + lim(int'(s[3:0]), 9);
               m_t  = mm * 60 + ss;
               m_p  = 0; m_fl = 0;
            end
            3'd1: begin
               mm   = lim(int'(s[7:4]), 9) * 10 + lim(int'(s[3:0]), 9);
               m_t  = mm * 60 + ss;
               m_p  = 0; m_fl = 0;
            end
            3'd2: m_fl = 0;
            3'd3: begin
               if (tick && m_t > 0) m_t = m_t - 1;
               m_p  = (m_p + 1) % c_TPS;
               m_fl = 0;
            end
            3'd4: begin
               if (tick) m_fl = !m_fl;
               m_p = (m_p + 1) % c_TPS;
            end
            3'd5: begin
               m_t = 0; m_p = 0; m_fl = 0;
            end
            default: ;
         endcase
      end
   endtask

   // One clock: apply inputs, advance the model, compare all outputs.
   task automatic step(input logic [2:0] st, input logic [7:0] s, input logic r);
      rst   = r;
      state = st;
      sw    = s;
      @(posedge clk);
      model_edge(r, st, s);
      #1;
      chk("sec",    32'(sec),    32'(to_bcd(m_t % 60)));
      chk("min",    32'(min),    32'(to_bcd(m_t / 60)));
      chk("cntfin", 32'(cntfin), 32'(m_cf));
      chk("ledr",   32'(ledr),   32'({10{m_fl}}));
   endtask

   task automatic preset(input logic [7:0] mv, input logic [7:0] sv);
      step(3'd1, mv, 1'b0);
      step(3'd0, sv, 1'b0);
   endtask

   initial begin
      int hold;
      logic [2:0] st;
      n_vec = 0; n_err = 0;
      m_t = 0; m_p = 0; m_fl = 0; m_cf = 0;
      rst = 1'b1; state = 3'd5; sw = 8'h00;
      @(negedge clk);

      step(3'd0, 8'h99, 1'b1);
      chk("rst_sec", 32'(sec), 32'h00);
      chk("rst_ledr", 32'(ledr), 32'h000);

      // Seconds preset and clamping
      step(3'd0, 8'h45, 1'b0);
      chk("setsec_45", 32'(sec), 32'h45);
      step(3'd0, 8'h7A, 1'b0);
      chk("setsec_clamp", 32'(sec), 32'h59);
      step(3'd1, 8'hAF, 1'b0);
      chk("setmin_clamp", 32'(min), 32'h99);

      // Borrow from minutes
      preset(8'h01, 8'h00);
      repeat (4) step(3'd3, 8'h00, 1'b0);
      chk("borrow_sec", 32'(sec), 32'h59);
      chk("borrow_min", 32'(min), 32'h00);
      repeat (4) step(3'd3, 8'h00, 1'b0);
      chk("dec_58", 32'(sec), 32'h58);

      // Count to zero and stay there
      preset(8'h00, 8'h02);
      repeat (8) step(3'd3, 8'h00, 1'b0);
      chk("zero_sec", 32'(sec), 32'h00);
      chk("zero_fin0", 32'(cntfin), 32'h0);
      step(3'd3, 8'h00, 1'b0);
      chk("zero_fin1", 32'(cntfin), 32'h1);
      repeat (6) step(3'd3, 8'h00, 1'b0);
      chk("zero_hold", 32'({min, sec}), 32'h0000);

      // Stop holds the prescaler mid-count
      preset(8'h00, 8'h10);
      repeat (2) step(3'd3, 8'h00, 1'b0);
      repeat (10) step(3'd2, 8'h00, 1'b0);
      chk("stop_hold", 32'(sec), 32'h10);
      step(3'd3, 8'h00, 1'b0);
      chk("resume_1", 32'(sec), 32'h10);
      step(3'd3, 8'h00, 1'b0);
      chk("resume_2", 32'(sec), 32'h09);

      // Finish flasher
      preset(8'h00, 8'h00);
      step(3'd4, 8'h00, 1'b0);
      chk("flash_entry", 32'(ledr), 32'h000);
      repeat (3) step(3'd4, 8'h00, 1'b0);
      chk("flash_on", 32'(ledr), 32'h3FF);
      repeat (4) step(3'd4, 8'h00, 1'b0);
      chk("flash_off", 32'(ledr), 32'h000);

      // Reset mid-count
      preset(8'h12, 8'h34);
      repeat (2) step(3'd3, 8'h00, 1'b0);
      chk("pre_rst", 32'({min, sec}), 32'h1234);
      step(3'd3, 8'h00, 1'b1);
      chk("rst_mid", 32'({min, sec, 7'd0, cntfin}), 32'h0);
      step(3'd3, 8'h00, 1'b0);
      chk("rst_fin", 32'(cntfin), 32'h1);

      // Undefined codes freeze everything
      preset(8'h03, 8'h21);
      step(3'd3, 8'h00, 1'b0);
      repeat (6) step(3'd6, 8'h55, 1'b0);
      chk("code6_hold", 32'({min, sec}), 32'h0321);

      // Randomized state sequences
      for (int i = 0; i < 150; i++) begin
         st   = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 2) == 0) st = 3'd3;
         hold = $urandom_range(1, 12);
         for (int k = 0; k < hold; k++) begin
            step(st, 8'($urandom), ($urandom_range(0, 60) == 0));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
